// File: rtl/tlul_flush_ctrl_pkg.sv
// Shared types for the TL-UL gate flush sequencer: sparse FSM encoding and defaults.
package tlul_flush_ctrl_pkg;

    localparam int unsigned TimeoutCyclesDefault = 1024;

    // Pairwise Hamming distance >= 5, so a single upset can never land on another legal state.
    typedef enum logic [8:0] {
        Idle      = 9'b000_000_111,
        Flushing  = 9'b000_111_000,
        Flushed   = 9'b111_000_000,
        Releasing = 9'b011_011_011,
        Timeout   = 9'b101_101_101
    } state_e;

endpackage

// File: rtl/tlul_gate_flush_ctrl.sv
// Drains a chain of TL-UL life-cycle gates downstream-first and reopens them in reverse,
// with a per-stage ack timeout and a sticky timeout flag.
module tlul_gate_flush_ctrl
    import tlul_flush_ctrl_pkg::*;
#(
    parameter int unsigned NumGates      = 3,
    parameter int unsigned TimeoutCycles = TimeoutCyclesDefault
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_start_i,
    input  logic                flush_release_i,
    output logic [NumGates-1:0] flush_req_o,
    input  logic [NumGates-1:0] flush_ack_i,
    input  logic [NumGates-1:0] resp_pending_i,
    output logic                busy_o,
    output logic                flushed_o,
    output logic                pending_o,
    output logic                timeout_o,
    output logic                err_o
);

    localparam int unsigned CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int unsigned IdxWidth  = (NumGates > 1) ? $clog2(NumGates) : 1;
    localparam bit          TimeoutEn = (TimeoutCycles != 0);
    localparam logic [CntWidth-1:0] TimerLast = CntWidth'(TimeoutCycles - 1);
    localparam logic [IdxWidth-1:0] LastIdx   = IdxWidth'(NumGates - 1);

    state_e                state_q;
    logic [IdxWidth-1:0]   idx_q;
    logic [NumGates-1:0]   req_q;
    logic [CntWidth-1:0]   timer_q;
    logic                  timeout_q;
    logic                  timer_expired;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + CntWidth'(1);
    endfunction

    assign timer_expired = TimeoutEn && (timer_q == TimerLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            idx_q     <= '0;
            req_q     <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                Idle: begin
                    if (flush_start_i) begin
                        state_q <= Flushing;
                        idx_q   <= '0;
                        req_q   <= NumGates'(1);
                        timer_q <= '0;
                    end
                end
                Flushing: begin
                    // An ack on the current stage beats a timer expiring in the same cycle.
                    if (flush_ack_i[idx_q]) begin
                        timer_q <= '0;
                        if (idx_q == LastIdx) begin
                            state_q <= Flushed;
                        end else begin
                            idx_q                         <= idx_q + IdxWidth'(1);
                            req_q[idx_q + IdxWidth'(1)]   <= 1'b1;
                        end
                    end else if (timer_expired) begin
                        state_q   <= Timeout;
                        timeout_q <= 1'b1;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= sat_inc(timer_q);
                    end
                end
                Flushed: begin
                    if (flush_release_i) begin
                        state_q        <= Releasing;
                        idx_q          <= LastIdx;
                        req_q[LastIdx] <= 1'b0;
                        timer_q        <= '0;
                    end
                end
                Releasing: begin
                    if (!flush_ack_i[idx_q]) begin
                        timer_q <= '0;
                        if (idx_q == '0) begin
                            state_q <= Idle;
                        end else begin
                            idx_q                       <= idx_q - IdxWidth'(1);
                            req_q[idx_q - IdxWidth'(1)] <= 1'b0;
                        end
                    end else if (timer_expired) begin
                        state_q   <= Timeout;
                        timeout_q <= 1'b1;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= sat_inc(timer_q);
                    end
                end
                Timeout: begin
                    // Gates that acked stay blocked until an explicit release reopens everything at once.
                    if (flush_release_i) begin
                        state_q <= Idle;
                        idx_q   <= '0;
                        req_q   <= '0;
                        timer_q <= '0;
                    end
                end
                default: begin
                    state_q   <= Timeout;
                    timeout_q <= 1'b1;
                    timer_q   <= '0;
                end
            endcase
        end
    end

    assign flush_req_o = req_q;
    assign busy_o      = (state_q != Idle);
    assign flushed_o   = (state_q == Flushed);
    assign pending_o   = |(resp_pending_i & req_q);
    assign timeout_o   = timeout_q;
    assign err_o       = !(state_q inside {Idle, Flushing, Flushed, Releasing, Timeout});

endmodule

// File: tb/tb_tlul_gate_flush_ctrl.sv
// Directed bench for tlul_gate_flush_ctrl with three gates and a 16-cycle stage timeout.
module tb_tlul_gate_flush_ctrl;
    import tlul_flush_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       flush_start;
    logic       flush_release;
    logic [2:0] flush_req;
    logic [2:0] flush_ack;
    logic [2:0] resp_pending;
    logic       busy, flushed, pending, timeout, err;

    // Gate model: each enabled gate mirrors its request straight back; ack_force injects stray acks.
    logic [2:0] ack_en;
    logic [2:0] ack_force;
    assign flush_ack = (flush_req & ack_en) | ack_force;

    int passes = 0;
    int total  = 0;

    tlul_gate_flush_ctrl #(
        .NumGates      (3),
        .TimeoutCycles (16)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .flush_start_i   (flush_start),
        .flush_release_i (flush_release),
        .flush_req_o     (flush_req),
        .flush_ack_i     (flush_ack),
        .resp_pending_i  (resp_pending),
        .busy_o          (busy),
        .flushed_o       (flushed),
        .pending_o       (pending),
        .timeout_o       (timeout),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_ni        = 1'b0;
        flush_start   = 1'b0;
        flush_release = 1'b0;
        resp_pending  = 3'b000;
        ack_en        = 3'b111;
        ack_force     = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", flush_req, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_flushed", flushed, 1'b0);
        check("rst_pending", pending, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_err", err, 1'b0);
        rst_ni = 1'b1;
        step();

        // Full flush with immediate acks, then ordered release
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        check("fl_req0", flush_req, 3'b001);
        check("fl_busy", busy, 1'b1);
        step();
        check("fl_req1", flush_req, 3'b011);
        step();
        check("fl_req2", flush_req, 3'b111);
        check("fl_notyet", flushed, 1'b0);
        step();
        check("fl_done", flushed, 1'b1);
        check("fl_req_all", flush_req, 3'b111);
        flush_release = 1'b1;
        step();
        flush_release = 1'b0;
        check("rel_req2", flush_req, 3'b011);
        check("rel_flushed", flushed, 1'b0);
        step();
        check("rel_req1", flush_req, 3'b001);
        step();
        check("rel_req0", flush_req, 3'b000);
        check("rel_busy", busy, 1'b1);
        step();
        check("rel_idle", busy, 1'b0);

        // Ack arrives on the cycle the timer reaches its last value: ack wins
        ack_en      = 3'b000;
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        repeat (15) step();
        check("race_pre_to", timeout, 1'b0);
        check("race_pre_req", flush_req, 3'b001);
        ack_en = 3'b001;
        step();
        check("race_req", flush_req, 3'b011);
        check("race_to", timeout, 1'b0);
        check("race_busy", busy, 1'b1);
        ack_en = 3'b111;
        step();
        step();
        check("race_flushed", flushed, 1'b1);

        // Start ignored in Flushed; release beats start; start ignored in Releasing
        flush_start = 1'b1;
        step();
        check("ign_fl_flushed", flushed, 1'b1);
        check("ign_fl_req", flush_req, 3'b111);
        flush_release = 1'b1;
        ack_force     = 3'b100;
        step();
        flush_release = 1'b0;
        check("both_req", flush_req, 3'b011);
        check("both_flushed", flushed, 1'b0);
        step();
        check("ign_rel_req", flush_req, 3'b011);
        check("ign_rel_busy", busy, 1'b1);
        flush_start = 1'b0;
        ack_force   = 3'b000;
        step();
        check("ign_rel_req1", flush_req, 3'b001);
        step();
        step();
        check("ign_rel_idle", busy, 1'b0);

        // Release ignored during Flushing; stray ack on gate 2 ignored while on gate 0
        ack_en       = 3'b000;
        resp_pending = 3'b010;
        flush_start  = 1'b1;
        step();
        flush_start = 1'b0;
        check("sp_req0", flush_req, 3'b001);
        flush_release = 1'b1;
        ack_force     = 3'b100;
        step();
        check("sp_req_hold", flush_req, 3'b001);
        check("sp_busy", busy, 1'b1);
        check("sp_flushed", flushed, 1'b0);
        check("sp_pending0", pending, 1'b0);
        flush_release = 1'b0;
        ack_force     = 3'b000;

        // Gate 1 never acks: stage times out after 16 cycles
        ack_en = 3'b001;
        step();
        check("to_req", flush_req, 3'b011);
        check("to_pending", pending, 1'b1);
        repeat (15) step();
        check("to_pre_flag", timeout, 1'b0);
        check("to_pre_req", flush_req, 3'b011);
        check("to_pre_busy", busy, 1'b1);
        step();
        check("to_flag", timeout, 1'b1);
        check("to_req_held", flush_req, 3'b011);
        check("to_flushed", flushed, 1'b0);
        check("to_busy", busy, 1'b1);
        flush_release = 1'b1;
        step();
        flush_release = 1'b0;
        check("to_rel_req", flush_req, 3'b000);
        check("to_rel_busy", busy, 1'b0);
        check("to_sticky", timeout, 1'b1);

        // Asynchronous reset in the middle of a flush
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        step();
        check("ar_pre_req", flush_req, 3'b011);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_req", flush_req, 3'b000);
        check("ar_busy", busy, 1'b0);
        check("ar_timeout", timeout, 1'b0);
        check("ar_pending", pending, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        check("ar_restart_req", flush_req, 3'b001);
        check("ar_restart_busy", busy, 1'b1);
        step();
        check("ar_restart_req1", flush_req, 3'b011);

        // Illegal state code: err_o immediately, Timeout on the next edge, requests held
        force dut.state_q = state_e'(9'b000_000_000);
        #1;
        check("bd_err", err, 1'b1);
        check("bd_busy", busy, 1'b1);
        step();
        check("bd_timeout", timeout, 1'b1);
        check("bd_req_held", flush_req, 3'b011);
        release dut.state_q;
        step();
        check("bd_state", dut.state_q, Timeout);
        check("bd_err_clear", err, 1'b0);
        check("bd_req_still", flush_req, 3'b011);
        flush_release = 1'b1;
        step();
        flush_release = 1'b0;
        check("bd_rel_req", flush_req, 3'b000);
        check("bd_rel_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/tlul_gate_flush_ctrl.md
Name: tlul_gate_flush_ctrl

Overview:
Sequences the flush handshake across NumGates TL-UL life-cycle gate instances that sit in a chain of bus segments. On a flush request it drains the gates in index order, downstream first (gate 0 first). Each gate must acknowledge before the next is asked. It then reports "all flushed" to the requester, typically the reset/power manager. On release it reopens the gates in reverse index order, and it bounds every stage with a timeout.

Parameters:
NumGates, 3, number of gate instances controlled (≥1).
TimeoutCycles, 1024, max cycles to wait per stage for ack (assert/deassert); 0 disables timeout.
CntWidth, $clog2(TimeoutCycles+1), stage timer width (derived, localparam).

Ports:
clk_i  input  1  clock
rst_ni  input  1  async active-low reset
flush_start_i  input  1  level; request to flush all gates (sampled in Idle only)
flush_release_i  input  1  level; request to reopen (sampled in Flushed/Timeout only)
flush_req_o  output  NumGates  per-gate flush_req, registered
flush_ack_i  input  NumGates  per-gate flush_ack
resp_pending_i  input  NumGates  per-gate resp_pending (status only)
busy_o  output  1  state != Idle
flushed_o  output  1  all gates acked, state == Flushed
pending_o  output  1  |(resp_pending_i & flush_req_o), combinational
timeout_o  output  1  sticky: some stage timed out; cleared only by reset
err_o  output  1  FSM encoding fault (combinational from state)

Behaviour:
- Reset values:
  - state=Idle, idx_q=0, req_q='0, timer=0, timeout_q=0.
  - All outputs 0.
- Mapping: flush_req_o = req_q. No combinational path from any input to flush_req_o.
- FSM: sparse-encoded, Hamming distance ≥3, flop via CALIPTRA_PRIM_FLOP_SPARSE_FSM.
  - An illegal encoding drives err_o=1 and req_q stays held.
  - The default branch targets Timeout.
- Idle:
  - If flush_start_i=1: next edge goes to Flushing with idx_q=0, req_q[0]=1, timer=0.
- Flushing:
  - req_q holds bits [idx_q:0].
  - If flush_ack_i[idx_q]=1 and idx_q=NumGates-1: go to Flushed.
  - Else if flush_ack_i[idx_q]=1: idx_q+1, set req_q[idx_q+1], timer=0. The next request is visible the cycle after the ack.
  - Else timer+1. If TimeoutCycles≠0 and timer==TimeoutCycles-1: go to Timeout.
- Flushed:
  - flushed_o=1; req_q all ones.
  - If flush_release_i=1: go to Releasing with idx_q=NumGates-1, clear req_q[NumGates-1], timer=0.
- Releasing:
  - Wait for flush_ack_i[idx_q]=0.
  - Then if idx_q=0: go to Idle.
  - Otherwise idx_q-1, clear req_q[idx_q-1], timer=0.
  - Timeout rule identical to Flushing.
- Timeout:
  - timeout_q set on entry.
  - req_q held, so gates that did ack stay blocked.
  - If flush_release_i=1: req_q='0 and go to Idle in one step, with no sequencing.
- Simultaneous events:
  - Ack and timer expiry in the same cycle: ack wins.
  - flush_start_i outside Idle: ignored.
  - flush_release_i outside Flushed/Timeout: ignored.
  - flush_start_i and flush_release_i both high in Flushed: release wins.
- Spurious inputs:
  - An ack on a bit not equal to idx_q is ignored.
  - An ack already high on stage entry is accepted that same cycle.
- Stage latency:
  - Minimum 1 cycle per gate.
  - Flushing N gates with immediate acks: flushed_o rises N+1 cycles after flush_start_i is sampled.
- Timer:
  - Saturates.
  - Counts only in Flushing/Releasing.
  - Cleared on every stage change.
- Reset mid-operation: asynchronous return to Idle with all req_q cleared. Gates then return to Active by their own logic.

Decomposition:
- Shared package tlul_flush_ctrl_pkg holds:
  - the sparse state_e typedef (Idle, Flushing, Flushed, Releasing, Timeout, 9-bit);
  - the default TimeoutCycles constant.
- No sub-module: the timer and index counter stay inline.
- Verification instantiates NumGates tlul_lc_gate instances as the DUT environment.

Test Plan:
- NumGates=3, acks returned 1 cycle after each req: after flush_start_i, flush_req_o steps 001→011→111; flushed_o=1 at cycle 4. Then flush_release_i steps 111→011→001→000 and busy_o falls.
- Gate 1 holds ack low with resp_pending_i[1]=1, TimeoutCycles=16: flush_req_o stays 011 and pending_o=1. Timeout is entered after 16 cycles with timeout_o=1; release gives flush_req_o=000, Idle, timeout_o still 1.
- Ack for gate 0 arrives on the same cycle the timer reaches 15: advance to idx 1, no timeout.
- flush_start_i asserted in Flushed or Releasing, flush_release_i during Flushing: no state change. Spurious flush_ack_i[2] while idx=0: ignored.
- rst_ni asserted mid-Flushing with flush_req_o=011: outputs 0 immediately, async. After deassertion, flush_start_i restarts at gate 0.
- Force an illegal state code via backdoor: err_o=1; the FSM goes to Timeout on the next edge.
